// File: rtl/hm_pkg.sv
// Shared HM result types and helpers: result layout, scheduler state and byte swap.
package hm_pkg;

    localparam int HASH_W    = 256;
    localparam int NONCE_W   = 32;
    localparam int RESULT_W  = HASH_W + NONCE_W;
    localparam int NUM_WORDS = 9;

    typedef logic [RESULT_W-1:0] hm_result_t;

    typedef enum logic {IDLE, SEND} hm_sched_state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/hm_result_fifo.sv
// DEPTH-entry result FIFO with registered pointers and occupancy count.
module hm_result_fifo
    import hm_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  hm_result_t    wdata,
    output hm_result_t    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    hm_result_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Push is accepted when full only if the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/hm_result_scheduler.sv
// Buffers HM results and streams each as 9 byte-swapped 32-bit words to the host.
module hm_result_scheduler
    import hm_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HASH_W-1:0] out_hash,
    input  logic [NONCE_W-1:0] nonce,
    input  logic              valid_hash_flag,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_word,
    output logic              out_last,
    output logic              hold_miner,
    output logic              overflow,
    output logic [7:0]        drop_count,
    output logic              busy
);

    localparam int        CW       = $clog2(DEPTH + 1);
    localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

    hm_result_t      head;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    hm_sched_state_t state;
    logic [3:0]      word_idx;
    logic [3:0]      sel;
    logic            push;
    logic            pop;
    logic            drop;
    logic            more;

    logic [NUM_WORDS-1:0][WORD_W-1:0] words;

    assign pop  = (state == SEND) && out_ready && (word_idx == LAST_IDX);
    assign push = valid_hash_flag && (!full || pop);
    assign drop = valid_hash_flag && full && !pop;
    // Something left to send after this pop, counting a result landing on the same edge.
    assign more = (count > CW'(1)) || push;

    hm_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({out_hash, nonce}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            word_idx   <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            overflow <= drop;
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
            case (state)
                IDLE: begin
                    word_idx <= '0;
                    if (!empty) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (word_idx > LAST_IDX) begin
                        state    <= IDLE;
                        word_idx <= '0;
                    end else if (out_ready) begin
                        if (word_idx == LAST_IDX) begin
                            word_idx <= '0;
                            state    <= more ? SEND : IDLE;
                        end else begin
                            word_idx <= word_idx + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    // The packed view puts the MS hash word at the top index, so word 0 maps to index 8.
    assign words = head;
    assign sel   = LAST_IDX - word_idx;

    always_comb begin
        out_word = '0;
        out_last = 1'b0;
        if ((state == SEND) && (word_idx <= LAST_IDX)) begin
            out_word = bswap32(words[sel]);
            out_last = (word_idx == LAST_IDX);
        end
    end

    assign out_valid  = (state == SEND);
    assign hold_miner = full;
    assign busy       = !empty || (state == SEND);

endmodule
